ddc_ctrl: RTL and testbench
===========================

Name: ddc_ctrl

Overview:
ddc_ctrl sequences one DDC channel built from an NCO LUT, a mixer and a CIC decimator.
- Generates the NCO phase addresses for the I and Q subchannels with a phase accumulator.
- Generates the CIC input-valid strobe (act) and the decimation strobe (act_out), delayed to line up with the LUT and mixer pipeline.
- Accepts tuning and decimation-rate changes through a valid/ready config port and applies them only at decimation-frame boundaries.
- Suppresses CIC output while the filter flushes after a change.

Parameters:
NCO_PHASE_WIDTH, 12, width of phase_i_o/phase_q_o (LUT address).
PHASE_ACC_WIDTH, 32, phase accumulator and FTW width; must be >= NCO_PHASE_WIDTH.
CIC_MAXRATE, 64, largest legal decimation rate.
RATE_WIDTH, 7, width of cfg_rate_i; must hold CIC_MAXRATE.
PIPE_LAT, 2, en_i-cycles from phase output to mixed sample at the CIC input (LUT 1 + mixer 1); must be >= 1.
FLUSH_DECIMS, 5, decimation frames with act_out suppressed after each config apply (= CIC_N).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
en_i  in  1  clock enable; all state advances only when en_i=1
cfg_valid_i  in  1  config request
cfg_ready_o  out  1  config can be accepted
cfg_ftw_i  in  PHASE_ACC_WIDTH  frequency tuning word
cfg_rate_i  in  RATE_WIDTH  decimation rate R
cfg_phase_rst_i  in  1  clear phase accumulator on apply
cfg_err_o  out  1  one-cycle pulse: illegal rate rejected
phase_i_o  out  NCO_PHASE_WIDTH  I-subchannel LUT address
phase_q_o  out  NCO_PHASE_WIDTH  Q-subchannel LUT address
act_o  out  1  CIC input valid (to act_i)
act_out_o  out  1  CIC decimation strobe (to act_out_i)
running_o  out  1  state==RUN

Behaviour:
Reset (rst_i=1 at a clock edge):
- acc=0, ftw=0, rate=0, decim count=0, flush count=0, pending empty.
- All delay-line stages cleared; state=IDLE.
- Outputs: phase_i_o=0, phase_q_o=2^(NCO_PHASE_WIDTH-2), act_o=0, act_out_o=0, running_o=0, cfg_err_o=0, cfg_ready_o=1.
- A reset mid-operation discards any pending config and in-flight strobes.

Config handshake (independent of en_i):
- Transfer when cfg_valid_i & cfg_ready_o.
- Legal R is 1..CIC_MAXRATE. If R is outside that range: cfg_err_o pulses next cycle, the config is dropped, and cfg_ready_o stays 1.
- A legal config loads the single pending register; cfg_ready_o=0 while the register is full.

States:
- IDLE: act_raw=0, acc frozen. A pending config is applied on the next en_i cycle -> FLUSH.
- FLUSH: act_raw=1 every en_i cycle. Raw decimation strobes are counted, but act_out_raw is forced to 0. After FLUSH_DECIMS raw strobes -> RUN.
- RUN: act_raw=1, act_out_raw=raw strobe.

Apply action:
- ftw<=cfg_ftw, rate<=cfg_rate, decim count<=0, flush count<=0.
- acc<=0 if cfg_phase_rst, otherwise acc continues.
- Pending register cleared; state<=FLUSH.

Counting and apply timing:
- Decim count runs 0..R-1 on en_i cycles. The raw strobe is asserted when count==R-1, then the count wraps to 0.
- In FLUSH/RUN, a pending config is applied on the en_i cycle where the raw strobe fires. The new rate counts from 0 on the next en_i cycle.
- A config that transfers in that same boundary cycle is not applied until the next boundary.
- A reconfig during FLUSH restarts the flush count at its apply.
- R=1: a strobe fires every cycle, so an apply happens on the first en_i cycle after acceptance.

Phase:
- acc advances acc+ftw mod 2^PHASE_ACC_WIDTH on each en_i cycle in FLUSH/RUN.
- phase_i_o = acc[MSB -: NCO_PHASE_WIDTH].
- phase_q_o = phase_i_o + 2^(NCO_PHASE_WIDTH-2) mod 2^NCO_PHASE_WIDTH (quarter-turn offset).
- Both are registered outputs.

Strobe delay:
- act_o and act_out_o are act_raw and act_out_raw delayed by PIPE_LAT en_i-qualified stages.
- With en_i=0, all outputs hold.
- act_out_o is only ever asserted together with act_o.

Decomposition:
- Package ddc_ctrl_pkg: state enum (IDLE, FLUSH, RUN), the quarter-turn constant, a rate-legality function.
- Sub-module ddc_strobe_delay: PIPE_LAT-deep enable-gated shift register, 2 bits wide, synchronous clear.

Test Plan:
1. Reset, then cfg ftw=0x10000000, R=4, phase_rst=1 -> phase_i_o steps 0x000, 0x100, 0x200, ...; phase_q_o = phase_i_o+0x400. act_o rises 2 en cycles after the first FLUSH cycle.
2. Same config -> the first 5 frames have act_out_o=0. Thereafter act_out_o pulses once every 4 act_o cycles (first pulse on act_o cycle 24); running_o rises after frame 5.
3. While in RUN with R=4, cfg R=8 asserted mid-frame -> cfg_ready_o=0 until the frame-end strobe. The new frames are 8 long, followed by 5 suppressed frames; there is no partial frame.
4. cfg R=0, then R=65 -> cfg_err_o pulses once each; state, rate and ftw are unchanged; cfg_ready_o stays 1.
5. en_i toggled 1/0 with R=2 -> outputs hold on en_i=0 cycles; strobe spacing is counted in en_i=1 cycles only.
6. rst_i asserted in RUN with a config pending -> next cycle all outputs are at reset values. The pending config is lost and IDLE is held until a new config arrives.

Source files
------------

// File: rtl/ddc_ctrl_pkg.sv
// rtl/ddc_ctrl_pkg.sv - shared types and helpers for the DDC channel sequencer
package ddc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Q subchannel leads I by a quarter turn: 2^(width-2) in LUT address units
    localparam int unsigned QUARTER_SHIFT = 2;

    function automatic int unsigned quarter_turn(input int unsigned phase_width);
        return 32'd1 << (phase_width - QUARTER_SHIFT);
    endfunction

    function automatic logic rate_ok(input int unsigned rate, input int unsigned max_rate);
        return (rate != 0) && (rate <= max_rate);
    endfunction

endpackage

// File: rtl/ddc_strobe_delay.sv
// rtl/ddc_strobe_delay.sv - enable-gated 2-bit shift register aligning strobes with the datapath
module ddc_strobe_delay #(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [DEPTH-1:0][1:0] stage_q;
    logic [DEPTH-1:0][1:0] stage_d;

    // Shift one stage per enabled cycle, hold otherwise
    always_comb begin
        stage_d = stage_q;
        if (en_i) begin
            stage_d[0] = d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Register stages with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ddc_ctrl.sv
// rtl/ddc_ctrl.sv - DDC channel sequencer: NCO phase, CIC strobes, frame-aligned reconfiguration
module ddc_ctrl
    import ddc_ctrl_pkg::*;
#(
    parameter int NCO_PHASE_WIDTH = 12,
    parameter int PHASE_ACC_WIDTH = 32,
    parameter int CIC_MAXRATE     = 64,
    parameter int RATE_WIDTH      = 7,
    parameter int PIPE_LAT        = 2,
    parameter int FLUSH_DECIMS    = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [PHASE_ACC_WIDTH-1:0] cfg_ftw_i,
    input  logic [RATE_WIDTH-1:0]      cfg_rate_i,
    input  logic                       cfg_phase_rst_i,
    output logic                       cfg_err_o,
    output logic [NCO_PHASE_WIDTH-1:0] phase_i_o,
    output logic [NCO_PHASE_WIDTH-1:0] phase_q_o,
    output logic                       act_o,
    output logic                       act_out_o,
    output logic                       running_o
);

    localparam int FW = $clog2(FLUSH_DECIMS + 1);
    localparam logic [NCO_PHASE_WIDTH-1:0] QUARTER =
        NCO_PHASE_WIDTH'(quarter_turn(NCO_PHASE_WIDTH));

    state_e                     state_q, state_d;
    logic [PHASE_ACC_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_ACC_WIDTH-1:0] ftw_q, ftw_d;
    logic [RATE_WIDTH-1:0]      rate_q, rate_d;
    logic [RATE_WIDTH-1:0]      cnt_q, cnt_d;
    logic [FW-1:0]              flush_q, flush_d;
    logic                       pend_valid_q, pend_valid_d;
    logic [PHASE_ACC_WIDTH-1:0] pend_ftw_q, pend_ftw_d;
    logic [RATE_WIDTH-1:0]      pend_rate_q, pend_rate_d;
    logic                       pend_prst_q, pend_prst_d;
    logic                       err_q, err_d;
    logic                       running_q, running_d;
    logic [NCO_PHASE_WIDTH-1:0] phi_i_q, phi_i_d;
    logic [NCO_PHASE_WIDTH-1:0] phi_q_q, phi_q_d;

    logic cfg_fire;
    logic active;
    logic strobe;
    logic apply;
    logic act_raw;
    logic act_out_raw;
    logic [1:0] dly_q;

    // Raw frame strobe and apply qualification; apply only consumes an already-registered config
    always_comb begin
        cfg_fire    = cfg_valid_i & ~pend_valid_q;
        active      = (state_q != ST_IDLE);
        strobe      = en_i & active & (cnt_q == rate_q - RATE_WIDTH'(1));
        apply       = en_i & pend_valid_q & ((state_q == ST_IDLE) | strobe);
        act_raw     = active;
        act_out_raw = strobe & (state_q == ST_RUN);
    end

    // Next-state for config capture, counters, accumulator and FSM
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        ftw_d        = ftw_q;
        rate_d       = rate_q;
        cnt_d        = cnt_q;
        flush_d      = flush_q;
        pend_valid_d = pend_valid_q;
        pend_ftw_d   = pend_ftw_q;
        pend_rate_d  = pend_rate_q;
        pend_prst_d  = pend_prst_q;
        err_d        = 1'b0;

        if (cfg_fire) begin
            if (rate_ok(32'(cfg_rate_i), CIC_MAXRATE)) begin
                pend_valid_d = 1'b1;
                pend_ftw_d   = cfg_ftw_i;
                pend_rate_d  = cfg_rate_i;
                pend_prst_d  = cfg_phase_rst_i;
            end else begin
                err_d = 1'b1;
            end
        end

        if (en_i && active) begin
            acc_d = acc_q + ftw_q;
            cnt_d = strobe ? '0 : cnt_q + RATE_WIDTH'(1);
            if (strobe && (state_q == ST_FLUSH)) begin
                if (flush_q == FW'(FLUSH_DECIMS - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
        end

        // Apply overrides the normal frame bookkeeping and restarts the flush
        if (apply) begin
            ftw_d        = pend_ftw_q;
            rate_d       = pend_rate_q;
            cnt_d        = '0;
            flush_d      = '0;
            pend_valid_d = 1'b0;
            state_d      = ST_FLUSH;
            if (pend_prst_q) begin
                acc_d = '0;
            end
        end

        running_d = (state_d == ST_RUN);
        phi_i_d   = acc_d[PHASE_ACC_WIDTH-1 -: NCO_PHASE_WIDTH];
        phi_q_d   = phi_i_d + QUARTER;
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            ftw_q        <= '0;
            rate_q       <= '0;
            cnt_q        <= '0;
            flush_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_ftw_q   <= '0;
            pend_rate_q  <= '0;
            pend_prst_q  <= 1'b0;
            err_q        <= 1'b0;
            running_q    <= 1'b0;
            phi_i_q      <= '0;
            phi_q_q      <= QUARTER;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            rate_q       <= rate_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            pend_valid_q <= pend_valid_d;
            pend_ftw_q   <= pend_ftw_d;
            pend_rate_q  <= pend_rate_d;
            pend_prst_q  <= pend_prst_d;
            err_q        <= err_d;
            running_q    <= running_d;
            phi_i_q      <= phi_i_d;
            phi_q_q      <= phi_q_d;
        end
    end

    ddc_strobe_delay #(
        .DEPTH(PIPE_LAT)
    ) u_strobe_delay (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (en_i),
        .d_i  ({act_out_raw, act_raw}),
        .q_o  (dly_q)
    );

    assign act_o       = dly_q[0];
    assign act_out_o   = dly_q[1];
    assign cfg_ready_o = ~pend_valid_q;
    assign cfg_err_o   = err_q;
    assign running_o   = running_q;
    assign phase_i_o   = phi_i_q;
    assign phase_q_o   = phi_q_q;

endmodule

// File: tb/tb_ddc_ctrl.sv
// tb/tb_ddc_ctrl.sv - directed self-checking bench for ddc_ctrl
module tb_ddc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_ftw;
    logic [6:0]  cfg_rate;
    logic        cfg_prst;
    logic        cfg_err;
    logic [11:0] phase_i;
    logic [11:0] phase_q;
    logic        act;
    logic        act_out;
    logic        running;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddc_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_ftw_i      (cfg_ftw),
        .cfg_rate_i     (cfg_rate),
        .cfg_phase_rst_i(cfg_prst),
        .cfg_err_o      (cfg_err),
        .phase_i_o      (phase_i),
        .phase_q_o      (phase_q),
        .act_o          (act),
        .act_out_o      (act_out),
        .running_o      (running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase_i"}, 32'(phase_i), 32'h000);
        check({tag, "_phase_q"}, 32'(phase_q), 32'h400);
        check({tag, "_act"}, 32'(act), 0);
        check({tag, "_act_out"}, 32'(act_out), 0);
        check({tag, "_running"}, 32'(running), 0);
        check({tag, "_err"}, 32'(cfg_err), 0);
        check({tag, "_ready"}, 32'(cfg_ready), 1);
    endtask

    initial begin
        int e;
        logic exp_ao;
        logic exp_run;

        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ftw   = '0;
        cfg_rate  = '0;
        cfg_prst  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("rst0");

        // Test 1/2/3/4: R=4 startup, R=8 reconfig mid-frame, illegal rates
        en        = 1'b1;
        cfg_valid = 1'b1;
        cfg_ftw   = 32'h1000_0000;
        cfg_rate  = 7'd4;
        cfg_prst  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("cfg1_ready_low", 32'(cfg_ready), 0);
        check("cfg1_idle", 32'(running), 0);
        tick();
        check("apply1_ready", 32'(cfg_ready), 1);
        check("apply1_phase", 32'(phase_i), 32'h000);
        check("apply1_act", 32'(act), 0);

        for (int k = 1; k <= 90; k++) begin
            tick();
            exp_ao  = (k == 25) || (k == 29) || (k == 33) || (k == 81) || (k == 89);
            exp_run = ((k >= 20) && (k < 32)) || (k >= 72);
            check($sformatf("t_act_k%0d", k), 32'(act), (k >= 2) ? 1 : 0);
            check($sformatf("t_act_out_k%0d", k), 32'(act_out), 32'(exp_ao));
            check($sformatf("t_running_k%0d", k), 32'(running), 32'(exp_run));
            check($sformatf("t_ready_k%0d", k), 32'(cfg_ready), ((k == 30) || (k == 31)) ? 0 : 1);
            check($sformatf("t_err_k%0d", k), 32'(cfg_err), ((k == 83) || (k == 84)) ? 1 : 0);
            check($sformatf("t_phase_i_k%0d", k), 32'(phase_i), (k * 32'h100) & 32'hFFF);
            check($sformatf("t_phase_q_k%0d", k), 32'(phase_q), (k * 32'h100 + 32'h400) & 32'hFFF);
            if (k == 29) begin
                cfg_valid = 1'b1;
                cfg_ftw   = 32'h1000_0000;
                cfg_rate  = 7'd8;
                cfg_prst  = 1'b0;
            end else if (k == 30) begin
                cfg_valid = 1'b0;
            end else if (k == 82) begin
                cfg_valid = 1'b1;
                cfg_ftw   = 32'hDEAD_BEEF;
                cfg_rate  = 7'd0;
                cfg_prst  = 1'b1;
            end else if (k == 83) begin
                cfg_rate = 7'd65;
            end else if (k == 84) begin
                cfg_valid = 1'b0;
            end
        end

        // Test 6: reset in RUN with a config pending
        cfg_valid = 1'b1;
        cfg_ftw   = 32'h0100_0000;
        cfg_rate  = 7'd2;
        cfg_prst  = 1'b0;
        tick();
        cfg_valid = 1'b0;
        check("pend_before_rst_ready", 32'(cfg_ready), 0);
        check("pend_before_rst_run", 32'(running), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst1");
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("post_rst_run_%0d", k), 32'(running), 0);
            check($sformatf("post_rst_act_%0d", k), 32'(act), 0);
            check($sformatf("post_rst_phase_%0d", k), 32'(phase_i), 0);
            check($sformatf("post_rst_ready_%0d", k), 32'(cfg_ready), 1);
        end

        // Test 5: R=2 with en toggling; spacing counted in enabled cycles only
        en        = 1'b1;
        cfg_valid = 1'b1;
        cfg_ftw   = 32'h0100_0000;
        cfg_rate  = 7'd2;
        cfg_prst  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        check("en_apply_run", 32'(running), 0);
        check("en_apply_phase", 32'(phase_i), 0);
        check("en_apply_act", 32'(act), 0);
        e = 0;
        for (int s = 1; s <= 40; s++) begin
            en = s[0];
            tick();
            if (en) e++;
            check($sformatf("en_act_s%0d", s), 32'(act), (e >= 2) ? 1 : 0);
            check($sformatf("en_act_out_s%0d", s), 32'(act_out), ((e >= 13) && e[0]) ? 1 : 0);
            check($sformatf("en_running_s%0d", s), 32'(running), (e >= 10) ? 1 : 0);
            check($sformatf("en_phase_i_s%0d", s), 32'(phase_i), (e * 32'h10) & 32'hFFF);
            check($sformatf("en_phase_q_s%0d", s), 32'(phase_q), (e * 32'h10 + 32'h400) & 32'hFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
